// File: rtl/buffer_pkgs.sv
// Shared decode-stage types: the decoded-instruction record handed from the
// decode skid buffer to dispatch, and the functional-unit selector inside it.
package buffer_pkgs;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_BRANCH = 2'd1,
        FU_MEM    = 2'd2
    } func_unit_t;

    typedef struct packed {
        func_unit_t  funcU;
        logic        rdUsed;
        logic [4:0]  rd;
        logic [15:0] imm;
    } decode_t;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Bundle between decode, the dispatch controller and the three reservation
// stations. The controller uses the slave view; the surrounding pipeline
// (or a bench) drives through the master view.
interface dispatch_ctrl_if #(
    parameter type D     = buffer_pkgs::decode_t,
    parameter int  TAG_W = 4
);
    logic             flush_i;
    logic             valid_dec_i;
    logic             ready_dec_o;
    D                 data_dec_i;
    logic             alu_valid_o;
    logic             br_valid_o;
    logic             mem_valid_o;
    D                 data_o;
    logic [TAG_W-1:0] tag_o;
    logic             alu_credit_i;
    logic             br_credit_i;
    logic             mem_credit_i;
    logic             stall_o;
    logic             err_o;

    modport slave (
        input  flush_i, valid_dec_i, data_dec_i,
        input  alu_credit_i, br_credit_i, mem_credit_i,
        output ready_dec_o, stall_o, err_o,
        output alu_valid_o, br_valid_o, mem_valid_o, data_o, tag_o
    );

    modport master (
        output flush_i, valid_dec_i, data_dec_i,
        output alu_credit_i, br_credit_i, mem_credit_i,
        input  ready_dec_o, stall_o, err_o,
        input  alu_valid_o, br_valid_o, mem_valid_o, data_o, tag_o
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Credit-based dispatch scheduler: steers each decoded instruction to the ALU,
// BRANCH or MEM reservation station named by funcU, tracks free RS slots with
// per-unit credit counters and stamps each dispatch with a wrapping tag.
// Unit index order everywhere: 0 = ALU, 1 = BRANCH, 2 = MEM.
module dispatch_ctrl #(
    parameter type D           = buffer_pkgs::decode_t,
    parameter int  ALU_CREDITS = 4,
    parameter int  BR_CREDITS  = 2,
    parameter int  MEM_CREDITS = 4,
    parameter int  TAG_W       = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    dispatch_ctrl_if.slave  bus
);

    localparam logic [2:0][3:0] CREDIT_MAX = {4'(MEM_CREDITS), 4'(BR_CREDITS), 4'(ALU_CREDITS)};

    // Next credit count: a same-cycle dispatch and return cancel; a return
    // into a full counter is dropped (reported separately as overflow).
    function automatic logic [3:0] credit_next(input logic [3:0] cnt, input logic [3:0] cap,
                                               input logic take, input logic give);
        logic [3:0] res;
        if (give && !take && (cnt == cap)) begin
            res = cnt;
        end else if (give && !take) begin
            res = cnt + 4'd1;
        end else if (take && !give) begin
            res = cnt - 4'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // A returned credit with no room for it is a protocol violation.
    function automatic logic credit_overflow(input logic [3:0] cnt, input logic [3:0] cap,
                                             input logic take, input logic give);
        return give && !take && (cnt == cap);
    endfunction

    logic [2:0][3:0]  cnt_r;
    logic [2:0][3:0]  cnt_nxt_s;
    logic [2:0]       ovf_s;
    logic [2:0]       unit_vec_s;
    logic [3:0]       sel_cnt_s;
    logic             has_credit_s;
    logic             fire_s;
    logic [2:0]       fire_vec_s;
    logic [2:0]       credit_s;
    logic [2:0]       valid_r;
    D                 data_r;
    logic [TAG_W-1:0] tag_r;
    logic [TAG_W-1:0] next_tag_r;
    logic             err_r;

    assign credit_s = {bus.mem_credit_i, bus.br_credit_i, bus.alu_credit_i};

    // Decode the target unit and pick its registered credit count.
    always_comb begin
        unit_vec_s = 3'b000;
        sel_cnt_s  = 4'd0;
        case (bus.data_dec_i.funcU)
            buffer_pkgs::FU_ALU: begin
                unit_vec_s = 3'b001;
                sel_cnt_s  = cnt_r[0];
            end
            buffer_pkgs::FU_BRANCH: begin
                unit_vec_s = 3'b010;
                sel_cnt_s  = cnt_r[1];
            end
            buffer_pkgs::FU_MEM: begin
                unit_vec_s = 3'b100;
                sel_cnt_s  = cnt_r[2];
            end
            default: begin
                unit_vec_s = 3'b000;
                sel_cnt_s  = 4'd0;
            end
        endcase
    end

    assign has_credit_s    = (sel_cnt_s != 4'd0);
    assign bus.ready_dec_o = !bus.flush_i && has_credit_s;
    assign bus.stall_o     = bus.valid_dec_i && !bus.flush_i && !has_credit_s;
    assign fire_s          = bus.valid_dec_i && bus.ready_dec_o;
    assign fire_vec_s      = fire_s ? unit_vec_s : 3'b000;

    // Per-unit credit bookkeeping for the coming edge.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_s     = 3'b000;
        for (int u = 0; u < 3; u++) begin
            cnt_nxt_s[u] = credit_next(cnt_r[u], CREDIT_MAX[u], fire_vec_s[u], credit_s[u]);
            ovf_s[u]     = credit_overflow(cnt_r[u], CREDIT_MAX[u], fire_vec_s[u], credit_s[u]);
        end
    end

    // Dispatch registers, credit counters, tag generator and sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_r    <= 3'b000;
            data_r     <= '0;
            tag_r      <= '0;
            next_tag_r <= '0;
            err_r      <= 1'b0;
            cnt_r      <= CREDIT_MAX;
        end else begin
            valid_r <= fire_vec_s;
            if (fire_s) begin
                data_r     <= bus.data_dec_i;
                tag_r      <= next_tag_r;
                next_tag_r <= next_tag_r + TAG_W'(1'b1);
            end
            // The RSs empty on flush, so every counter returns to full and
            // any credit returned in the same cycle is already accounted for.
            if (bus.flush_i) begin
                cnt_r <= CREDIT_MAX;
            end else begin
                cnt_r <= cnt_nxt_s;
                if (|ovf_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign bus.alu_valid_o = valid_r[0];
    assign bus.br_valid_o  = valid_r[1];
    assign bus.mem_valid_o = valid_r[2];
    assign bus.data_o      = data_r;
    assign bus.tag_o       = tag_r;
    assign bus.err_o       = err_r;

endmodule
